// File: rtl/sid_clk_pkg.sv
// Shared mode encodings and elaboration-time increment helpers for the SID clock generator.
package sid_clk_pkg;

    localparam logic [1:0] MODE_LEG  = 2'd0;
    localparam logic [1:0] MODE_PAL  = 2'd1;
    localparam logic [1:0] MODE_NTSC = 2'd2;
    localparam logic [1:0] MODE_CUST = 2'd3;

    localparam int unsigned ACC_W_DEF = 32;

    // Phase increment for an output frequency f, rounded to nearest.
    function automatic logic [63:0] calc_inc(input int unsigned f,
                                             input int unsigned sys_clk,
                                             input int unsigned acc_w);
        logic [63:0] num;
        num = (64'(f) << acc_w) + 64'(sys_clk / 2);
        return num / 64'(sys_clk);
    endfunction

    // Largest increment that still leaves at least two clk per phase.
    function automatic logic [63:0] calc_inc_max(input int unsigned acc_w);
        return 64'd1 << (acc_w - 2);
    endfunction

    localparam logic [63:0] INC_MAX = calc_inc_max(ACC_W_DEF);

endpackage

// File: rtl/sid_nco.sv
// Phase accumulator for the SID clock: adds the active increment each clk,
// reports the carry (wrap) and can be held at zero while stopped.
module sid_nco #(
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] inc,
    input  logic             hold,
    output logic             msb,
    output logic             msb_next,
    output logic             wrap
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_next;
    logic             carry;

    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, inc};
    assign acc_next         = hold ? '0 : acc_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    // A carry out of the top bit is always the 1->0 edge, since inc < 2^(ACC_W-1).
    assign wrap     = carry;
    assign msb      = acc[ACC_W-1];
    assign msb_next = acc_next[ACC_W-1];

endmodule

// File: rtl/sid_clk_gen.sv
// NCO-based SID phi2 clock generator with glitch-free mode switching and stop/start.
// Define SIDCLK_CYC_CNT_EN to build the rising-edge cycle counter behind cyc_cnt.
module sid_clk_gen
    import sid_clk_pkg::*;
#(
    parameter int unsigned SYS_CLK = 20000000,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned F_LEG   = 1000000,
    parameter int unsigned F_PAL   = 985248,
    parameter int unsigned F_NTSC  = 1022727
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [ACC_W-1:0] cust_inc,
    input  logic             cnt_clr,
    output logic             sid_clk,
    output logic             phi_rise,
    output logic             phi_fall,
    output logic [1:0]       mode_act,
    output logic [31:0]      cyc_cnt
);

    if (ACC_W < 16 || ACC_W > 32) begin : g_acc_w_check
        $error("sid_clk_gen: ACC_W must lie in 16..32");
    end

    if (F_LEG > SYS_CLK / 4 || F_PAL > SYS_CLK / 4 || F_NTSC > SYS_CLK / 4) begin : g_freq_check
        $error("sid_clk_gen: every output frequency must be <= SYS_CLK/4");
    end

    localparam logic [63:0]      INC_LEG_W  = calc_inc(F_LEG, SYS_CLK, ACC_W);
    localparam logic [63:0]      INC_PAL_W  = calc_inc(F_PAL, SYS_CLK, ACC_W);
    localparam logic [63:0]      INC_NTSC_W = calc_inc(F_NTSC, SYS_CLK, ACC_W);
    localparam logic [63:0]      INC_MAX_W  = calc_inc_max(ACC_W);
    localparam logic [ACC_W-1:0] INC_LEG    = INC_LEG_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC_PAL    = INC_PAL_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC_NTSC   = INC_NTSC_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC_CLAMP  = INC_MAX_W[ACC_W-1:0];

    logic [ACC_W-1:0] sel_inc;
    logic [ACC_W-1:0] pend_inc;
    logic [ACC_W-1:0] inc_act;
    logic [1:0]       pend_mode;
    logic [1:0]       mode_reg;
    logic             msb;
    logic             msb_next;
    logic             wrap;
    logic             hold;

    always_comb begin
        sel_inc = INC_LEG;
        case (mode)
            MODE_LEG:  sel_inc = INC_LEG;
            MODE_PAL:  sel_inc = INC_PAL;
            MODE_NTSC: sel_inc = INC_NTSC;
            MODE_CUST: sel_inc = (cust_inc > INC_CLAMP) ? INC_CLAMP : cust_inc;
            default:   sel_inc = INC_LEG;
        endcase
    end

    // The rate only changes at a wrap, so the new value begins with a fresh low phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_inc  <= INC_LEG;
            pend_mode <= MODE_LEG;
            inc_act   <= INC_LEG;
            mode_reg  <= MODE_LEG;
        end else begin
            pend_inc  <= sel_inc;
            pend_mode <= mode;
            if (wrap) begin
                inc_act  <= pend_inc;
                mode_reg <= pend_mode;
            end
        end
    end

    // Stopping never cuts a high phase short: zero only while low or at the closing wrap.
    assign hold = ~en & (~msb | wrap);

    sid_nco #(
        .ACC_W (ACC_W)
    ) u_nco (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc_act),
        .hold     (hold),
        .msb      (msb),
        .msb_next (msb_next),
        .wrap     (wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phi_rise <= 1'b0;
            phi_fall <= 1'b0;
        end else begin
            phi_rise <= msb_next & ~msb;
            phi_fall <= ~msb_next & msb;
        end
    end

    assign sid_clk  = msb;
    assign mode_act = mode_reg;

`ifdef SIDCLK_CYC_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (phi_rise) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign cyc_cnt = cnt;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign cyc_cnt        = '0;
`endif

endmodule

// File: tb/tb_sid_clk_gen.sv
// Self-checking bench for sid_clk_gen: rates, phase lengths, mode switching, clamp, stop/start, counter, reset.
module tb_sid_clk_gen;

    localparam real TWO_POW = 4294967296.0;
    localparam real SYS_HZ  = 20000000.0;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        en       = 1'b0;
    logic [1:0]  mode     = 2'd0;
    logic [31:0] cust_inc = 32'd0;
    logic        cnt_clr  = 1'b0;
    logic        sid_clk;
    logic        phi_rise;
    logic        phi_fall;
    logic [1:0]  mode_act;
    logic [31:0] cyc_cnt;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    logic   prev_sid = 1'b0;
    int     strobe_err = 0;
    int     run_len = 0;
    bit     rec = 1'b0;
    int     min_hi, max_hi, min_lo, max_lo;

    sid_clk_gen #(
        .SYS_CLK (20000000),
        .ACC_W   (32),
        .F_LEG   (1000000),
        .F_PAL   (985248),
        .F_NTSC  (1022727)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .cust_inc (cust_inc),
        .cnt_clr  (cnt_clr),
        .sid_clk  (sid_clk),
        .phi_rise (phi_rise),
        .phi_fall (phi_fall),
        .mode_act (mode_act),
        .cyc_cnt  (cyc_cnt)
    );

    always #5 clk = ~clk;

    function automatic longint inc_of(input real f);
        return longint'($floor(f * TWO_POW / SYS_HZ + 0.5));
    endfunction

    // One clk step, sampled on the falling edge; tracks strobe alignment and phase lengths.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst !== 1'b1) begin
            prev_sid = 1'b0;
            run_len  = 0;
        end else begin
            if (phi_rise !== (sid_clk & ~prev_sid) || phi_fall !== (~sid_clk & prev_sid))
                strobe_err++;
            if (sid_clk !== prev_sid) begin
                if (rec) begin
                    if (prev_sid) begin
                        if (run_len < min_hi) min_hi = run_len;
                        if (run_len > max_hi) max_hi = run_len;
                    end else begin
                        if (run_len < min_lo) min_lo = run_len;
                        if (run_len > max_lo) max_lo = run_len;
                    end
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_sid = sid_clk;
        end
    endtask

    task automatic wait_edge(input bit rise, input string name, input int budget,
                             output int waited, output bit ok);
        ok     = 1'b0;
        waited = 0;
        while (waited < budget && !ok) begin
            tick();
            waited++;
            if ((rise ? phi_rise : phi_fall) === 1'b1) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s timeout: no %s strobe within %0d clk", name, rise ? "rise" : "fall", budget);
        end
    endtask

    // Spans of n rises and every phase length, against the ideal period 2^32/inc.
    task automatic measure(input string name, input int n, input longint inc);
        real    p, hp;
        int     span_lo, span_hi, ph_lo, ph_hi, w, budget;
        bit     ok;
        longint t0, span;
        p       = TWO_POW / real'(inc);
        hp      = p / 2.0;
        span_lo = int'($floor(p * real'(n)));
        span_hi = int'($ceil(p * real'(n)));
        ph_lo   = int'($floor(hp));
        ph_hi   = int'($ceil(hp));
        budget  = 2 * int'($ceil(p)) + 8;
        rec     = 1'b0;
        wait_edge(1'b1, name, budget, w, ok);
        if (!ok) return;
        min_hi = 1 << 30; max_hi = 0; min_lo = 1 << 30; max_lo = 0;
        rec = 1'b1;
        t0  = cyc;
        for (int k = 0; k < n; k++) begin
            wait_edge(1'b1, name, budget, w, ok);
            if (!ok) begin
                rec = 1'b0;
                return;
            end
        end
        rec  = 1'b0;
        span = cyc - t0;
        total++;
        if (span < span_lo || span > span_hi) begin
            bad++;
            $display("[TB] FAIL %s_span: got %0d clk, want %0d..%0d", name, span, span_lo, span_hi);
        end
        total++;
        if (min_hi < ph_lo || max_hi > ph_hi) begin
            bad++;
            $display("[TB] FAIL %s_high_phase: got %0d..%0d clk, want %0d..%0d", name, min_hi, max_hi, ph_lo, ph_hi);
        end
        total++;
        if (min_lo < ph_lo || max_lo > ph_hi) begin
            bad++;
            $display("[TB] FAIL %s_low_phase: got %0d..%0d clk, want %0d..%0d", name, min_lo, max_lo, ph_lo, ph_hi);
        end
    endtask

    task automatic test_reset();
        int highs;
        #1 rst = 1'b0;
        repeat (3) tick();
        total++; if (sid_clk !== 1'b0)   begin bad++; $display("[TB] FAIL reset_sid_clk: got %b want 0", sid_clk); end
        total++; if (phi_rise !== 1'b0)  begin bad++; $display("[TB] FAIL reset_phi_rise: got %b want 0", phi_rise); end
        total++; if (phi_fall !== 1'b0)  begin bad++; $display("[TB] FAIL reset_phi_fall: got %b want 0", phi_fall); end
        total++; if (mode_act !== 2'd0)  begin bad++; $display("[TB] FAIL reset_mode_act: got %0d want 0", mode_act); end
        total++; if (cyc_cnt !== 32'd0)  begin bad++; $display("[TB] FAIL reset_cyc_cnt: got %0d want 0", cyc_cnt); end
        rst   = 1'b1;
        highs = 0;
        repeat (30) begin
            tick();
            if (sid_clk !== 1'b0) highs++;
        end
        total++; if (highs != 0) begin bad++; $display("[TB] FAIL idle_disabled: got %0d high clk, want 0", highs); end
    endtask

    task automatic test_legacy();
        en = 1'b1;
        measure("legacy", 1000, inc_of(1000000.0));
    endtask

    task automatic test_mid_switch();
        int         hi, lo_b, hi_b;
        bit         seen;
        logic [1:0] pre;
        real        hp;
        hp   = TWO_POW / real'(inc_of(1000000.0)) / 2.0;
        lo_b = int'($floor(hp));
        hi_b = int'($ceil(hp));
        tick();
        tick();
        mode = 2'd2;
        hi   = 3;
        seen = 1'b0;
        pre  = 2'bxx;
        for (int i = 0; i < 40 && !seen; i++) begin
            pre = mode_act;
            tick();
            if (phi_fall === 1'b1) seen = 1'b1;
            else hi++;
        end
        total++; if (!seen) begin bad++; $display("[TB] FAIL switch_fall: got no fall, want one within 40 clk"); end
        total++; if (hi < lo_b || hi > hi_b) begin bad++; $display("[TB] FAIL switch_high_len: got %0d clk, want %0d..%0d", hi, lo_b, hi_b); end
        total++; if (pre !== 2'd0) begin bad++; $display("[TB] FAIL switch_mode_before: got %0d want 0", pre); end
        total++; if (mode_act !== 2'd2) begin bad++; $display("[TB] FAIL switch_mode_at_fall: got %0d want 2", mode_act); end
        measure("ntsc", 1000, inc_of(1022727.0));
    endtask

    task automatic test_pal();
        int w;
        bit ok;
        rst  = 1'b0;
        mode = 2'd1;
        repeat (3) tick();
        rst = 1'b1;
        wait_edge(1'b0, "pal_first_fall", 60, w, ok);
        total++; if (mode_act !== 2'd1) begin bad++; $display("[TB] FAIL pal_mode_act: got %0d want 1", mode_act); end
        measure("pal", 1000, inc_of(985248.0));
    endtask

    task automatic test_custom();
        int          w, highs;
        bit          ok;
        logic [31:0] r;
        mode     = 2'd3;
        cust_inc = 32'hFFFF_FFFF;
        repeat (2) wait_edge(1'b0, "clamp_apply", 60, w, ok);
        measure("clamp_max", 20, 64'h4000_0000);
        r = $urandom;
        if (r <= 32'h4000_0000) r = r | 32'h8000_0000;
        cust_inc = r;
        repeat (2) wait_edge(1'b0, "clamp_rand_apply", 20, w, ok);
        measure("clamp_rand", 20, 64'h4000_0000);
        for (int t = 0; t < 3; t++) begin
            r        = $urandom_range(32'h4000_0000, 32'h0800_0000);
            cust_inc = r;
            repeat (2) wait_edge(1'b0, "cust_apply", 80, w, ok);
            measure($sformatf("cust_%08h", r), 40, longint'(r));
        end
        cust_inc = 32'h4000_0000;
        repeat (2) wait_edge(1'b0, "zero_prep", 80, w, ok);
        cust_inc = 32'd0;
        wait_edge(1'b0, "zero_fall", 10, w, ok);
        highs = 0;
        repeat (100) begin
            tick();
            if (sid_clk !== 1'b0) highs++;
        end
        total++; if (highs != 0) begin bad++; $display("[TB] FAIL zero_inc_stopped: got %0d high clk, want 0", highs); end
        total++; if (mode_act !== 2'd3) begin bad++; $display("[TB] FAIL zero_inc_mode: got %0d want 3", mode_act); end
    endtask

    task automatic test_stop_start();
        int  hi, w, highs, lo_b, hi_b;
        bit  ok, seen;
        real hp;
        hp   = TWO_POW / real'(inc_of(1000000.0)) / 2.0;
        lo_b = int'($floor(hp));
        hi_b = int'($ceil(hp));
        rst  = 1'b0;
        mode = 2'd0;
        en   = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        wait_edge(1'b1, "stop_align", 40, w, ok);
        tick();
        tick();
        en   = 1'b0;
        hi   = 3;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (phi_fall === 1'b1) seen = 1'b1;
            else hi++;
        end
        total++; if (!seen) begin bad++; $display("[TB] FAIL stop_fall: got no fall, want one within 40 clk"); end
        total++; if (hi < lo_b || hi > hi_b) begin bad++; $display("[TB] FAIL stop_high_len: got %0d clk, want %0d..%0d", hi, lo_b, hi_b); end
        highs = 0;
        repeat (42) begin
            tick();
            if (sid_clk !== 1'b0) highs++;
        end
        total++; if (highs != 0) begin bad++; $display("[TB] FAIL stop_held_low: got %0d high clk, want 0", highs); end
        en = 1'b1;
        wait_edge(1'b1, "start_rise", 40, w, ok);
        total++; if (w < 9 || w > 11) begin bad++; $display("[TB] FAIL start_latency: got %0d clk, want 9..11", w); end
    endtask

    task automatic test_counter();
        int w, n;
        bit ok;
        n = 37;
        wait_edge(1'b1, "cnt_align", 40, w, ok);
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int k = 0; k < n; k++) wait_edge(1'b1, "cnt_rise", 40, w, ok);
        tick();
`ifdef SIDCLK_CYC_CNT_EN
        total++; if (cyc_cnt !== 32'(n)) begin bad++; $display("[TB] FAIL cnt_value: got %0d want %0d", cyc_cnt, n); end
`else
        total++; if (cyc_cnt !== 32'd0) begin bad++; $display("[TB] FAIL cnt_tied: got %0d want 0", cyc_cnt); end
`endif
        wait_edge(1'b1, "cnt_clr_rise", 40, w, ok);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        total++; if (cyc_cnt !== 32'd0) begin bad++; $display("[TB] FAIL cnt_clr_priority: got %0d want 0", cyc_cnt); end
    endtask

    task automatic test_async_reset();
        int w;
        bit ok;
        mode = 2'd1;
        repeat (2) wait_edge(1'b0, "areset_apply", 60, w, ok);
        wait_edge(1'b1, "areset_rise", 40, w, ok);
        tick();
        tick();
        total++; if (mode_act !== 2'd1) begin bad++; $display("[TB] FAIL areset_pre_mode: got %0d want 1", mode_act); end
        total++; if (sid_clk !== 1'b1)  begin bad++; $display("[TB] FAIL areset_pre_high: got %b want 1", sid_clk); end
        #2 rst = 1'b0;
        #1;
        total++; if (sid_clk !== 1'b0)  begin bad++; $display("[TB] FAIL areset_sid_clk: got %b want 0", sid_clk); end
        total++; if (phi_rise !== 1'b0) begin bad++; $display("[TB] FAIL areset_phi_rise: got %b want 0", phi_rise); end
        total++; if (phi_fall !== 1'b0) begin bad++; $display("[TB] FAIL areset_phi_fall: got %b want 0", phi_fall); end
        total++; if (mode_act !== 2'd0) begin bad++; $display("[TB] FAIL areset_mode_act: got %0d want 0", mode_act); end
        total++; if (cyc_cnt !== 32'd0) begin bad++; $display("[TB] FAIL areset_cyc_cnt: got %0d want 0", cyc_cnt); end
        tick();
        rst = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_mid_switch();
        test_pal();
        test_custom();
        test_stop_start();
        test_counter();
        test_async_reset();
        total++;
        if (strobe_err != 0) begin
            bad++;
            $display("[TB] FAIL strobe_alignment: got %0d misaligned clk, want 0", strobe_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
